// File: rtl/dkong3_obj_scan.sv
// Per-line sprite scanner: walks object RAM after each H_START and copies the objects
// that intersect the prepared line into the line buffer. Optional: DKONG3_OBJSCAN_FLIP_EN.
module dkong3_obj_scan #(
    parameter int N_OBJ    = 104,
    parameter int MAX_LINE = 16
) (
    input  logic       I_CLK,
    input  logic       I_RESET_n,
    input  logic       I_CE,
    input  logic       I_H_START,
    input  logic [7:0] I_VPOS,
    input  logic       I_FLIP,
    output logic [9:0] O_OBJ_A,
    input  logic [7:0] I_OBJ_D,
    output logic [5:0] O_LB_A,
    output logic [7:0] O_LB_D,
    output logic       O_LB_WE,
    output logic [4:0] O_LB_CNT,
    output logic       O_BUSY,
    output logic       O_DONE,
    output logic       O_OVF
);
    localparam int               IDX_W    = $clog2(N_OBJ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [4:0]       SLOT_MAX = 5'(MAX_LINE);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_Y, S_TEST, S_CP1, S_CP2, S_CP3, S_NEXT, S_FIN
    } state_t;

    state_t           r_state, w_state_nx;
    logic [IDX_W-1:0] r_idx, w_idx_nx;
    logic [4:0]       r_slot, w_slot_nx;
    logic [7:0]       r_line, w_line_nx;
    logic [9:0]       r_obj_a, w_obj_a_nx;
    logic [5:0]       r_lb_a, w_lb_a_nx;
    logic [7:0]       r_lb_d, w_lb_d_nx;
    logic             r_lb_we, w_lb_we_nx;
    logic [4:0]       r_lb_cnt, w_lb_cnt_nx;
    logic             r_busy, w_busy_nx;
    logic             r_done, w_done_nx;
    logic             r_ovf, w_ovf_nx;

    logic [7:0] w_start_line;
    logic [9:0] w_base;
    logic [9:0] w_next_base;
    logic [7:0] w_row;
    logic       w_hit;

`ifdef DKONG3_OBJSCAN_FLIP_EN
    assign w_start_line = I_FLIP ? ~I_VPOS : I_VPOS;
`else
    logic w_unused_flip;
    assign w_unused_flip = I_FLIP;
    assign w_start_line  = I_VPOS;
`endif

    assign w_base      = 10'(r_idx) << 2;
    assign w_next_base = 10'(r_idx + IDX_ONE) << 2;
    assign w_row       = r_line - I_OBJ_D;
    assign w_hit       = (I_OBJ_D != 8'd0) && (w_row[7:4] == 4'd0);

    // Outputs are registered next-state decodes, so the address register is loaded one
    // step ahead: each state's read data is already on I_OBJ_D while that state runs.
    always_comb begin
        w_state_nx  = r_state;
        w_idx_nx    = r_idx;
        w_slot_nx   = r_slot;
        w_line_nx   = r_line;
        w_obj_a_nx  = r_obj_a;
        w_lb_a_nx   = r_lb_a;
        w_lb_d_nx   = r_lb_d;
        w_lb_we_nx  = 1'b0;
        w_lb_cnt_nx = r_lb_cnt;
        w_busy_nx   = r_busy;
        w_done_nx   = 1'b0;
        w_ovf_nx    = r_ovf;

        case (r_state)
            S_IDLE: ;
            S_RD_Y: begin
                w_obj_a_nx = w_base + 10'd1;
                w_state_nx = S_TEST;
            end
            S_TEST: begin
                if (w_hit) begin
                    w_lb_we_nx = 1'b1;
                    w_lb_a_nx  = {r_slot[3:0], 2'd0};
                    w_lb_d_nx  = {4'h0, w_row[3:0]};
                    w_obj_a_nx = w_base + 10'd2;
                    w_state_nx = S_CP1;
                end else begin
                    w_state_nx = S_NEXT;
                end
            end
            S_CP1: begin
                w_lb_we_nx = 1'b1;
                w_lb_a_nx  = {r_slot[3:0], 2'd1};
                w_lb_d_nx  = I_OBJ_D;
                w_obj_a_nx = w_base + 10'd3;
                w_state_nx = S_CP2;
            end
            S_CP2: begin
                w_lb_we_nx = 1'b1;
                w_lb_a_nx  = {r_slot[3:0], 2'd2};
                w_lb_d_nx  = I_OBJ_D;
                w_state_nx = S_CP3;
            end
            S_CP3: begin
                w_lb_we_nx = 1'b1;
                w_lb_a_nx  = {r_slot[3:0], 2'd3};
                w_lb_d_nx  = I_OBJ_D;
                w_slot_nx  = r_slot + 5'd1;
                w_state_nx = S_NEXT;
            end
            S_NEXT: begin
                if ((r_slot == SLOT_MAX) || (r_idx == LAST_IDX)) begin
                    w_ovf_nx    = (r_slot == SLOT_MAX) && (r_idx < LAST_IDX);
                    w_lb_cnt_nx = r_slot;
                    w_done_nx   = 1'b1;
                    w_busy_nx   = 1'b0;
                    w_state_nx  = S_FIN;
                end else begin
                    w_idx_nx   = r_idx + IDX_ONE;
                    w_obj_a_nx = w_next_base;
                    w_state_nx = S_RD_Y;
                end
            end
            S_FIN: w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase

        // A new start pulse always wins, abandoning any scan in flight.
        if (I_H_START) begin
            w_line_nx  = w_start_line;
            w_idx_nx   = '0;
            w_slot_nx  = 5'd0;
            w_obj_a_nx = 10'd0;
            w_lb_we_nx = 1'b0;
            w_done_nx  = 1'b0;
            w_busy_nx  = 1'b1;
            w_state_nx = S_RD_Y;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_slot   <= 5'd0;
            r_line   <= 8'd0;
            r_obj_a  <= 10'd0;
            r_lb_a   <= 6'd0;
            r_lb_d   <= 8'd0;
            r_lb_we  <= 1'b0;
            r_lb_cnt <= 5'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (I_CE) begin
            r_state  <= w_state_nx;
            r_idx    <= w_idx_nx;
            r_slot   <= w_slot_nx;
            r_line   <= w_line_nx;
            r_obj_a  <= w_obj_a_nx;
            r_lb_a   <= w_lb_a_nx;
            r_lb_d   <= w_lb_d_nx;
            r_lb_we  <= w_lb_we_nx;
            r_lb_cnt <= w_lb_cnt_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
            r_ovf    <= w_ovf_nx;
        end
    end

    assign O_OBJ_A  = r_obj_a;
    assign O_LB_A   = r_lb_a;
    assign O_LB_D   = r_lb_d;
    assign O_LB_WE  = r_lb_we;
    assign O_LB_CNT = r_lb_cnt;
    assign O_BUSY   = r_busy;
    assign O_DONE   = r_done;
    assign O_OVF    = r_ovf;
endmodule
